// File: rtl/mux_arb_nto1.sv
// mux_arb_nto1: N-to-1 channel multiplexer with a single registered output beat.
// The channel is chosen either by an explicit select (MODE=0) or by round-robin
// arbitration over the valid channels (MODE=1). o_ready is combinational, and the
// output register gives a one-cycle latency with full throughput.
module mux_arb_nto1 #(
    parameter int  WIDTH = 32,
    parameter int  NCH   = 4,
    parameter int  MODE  = 0,
    localparam int SW    = $clog2(NCH)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NCH*WIDTH-1:0]   i_data,
    input  logic [NCH-1:0]         i_valid,
    output logic [NCH-1:0]         o_ready,
    input  logic [SW-1:0]          i_sel,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [SW-1:0]          o_grant
);

    logic [WIDTH-1:0] ch_data [NCH];

    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;
    logic [SW-1:0]    grant_reg;
    logic [SW-1:0]    rr_ptr_reg;
    logic [SW-1:0]    rr_ptr_next;

    logic             can_load;
    logic [SW:0]      rr_sum;
    logic [SW-1:0]    rr_idx;
    logic             rr_found;
    logic [SW-1:0]    pick_idx;
    logic             pick_found;
    logic             accept;

    // The output register can take a new beat when it is empty or being drained.
    assign can_load = ~valid_reg | i_ready;

    // Per-channel data slices and one-hot ready; ready is forced low during reset.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            assign ch_data[gi] = i_data[gi*WIDTH +: WIDTH];
            assign o_ready[gi] = i_reset & can_load & pick_found & (pick_idx == SW'(gi));
        end
    endgenerate

    // Round-robin search: scan offsets from the highest down so the nearest
    // valid channel at or after rr_ptr is the one left in rr_idx.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_sum   = '0;
        for (int off = NCH - 1; off >= 0; off--) begin
            rr_sum = {1'b0, rr_ptr_reg} + (SW+1)'(off);
            if (rr_sum >= (SW+1)'(NCH)) begin
                rr_sum = rr_sum - (SW+1)'(NCH);
            end
            if (i_valid[rr_sum[SW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = rr_sum[SW-1:0];
            end
        end
    end

    // Candidate channel: explicit select (rejected when out of range) or arbiter pick.
    always_comb begin
        if (MODE == 0) begin
            pick_idx   = i_sel;
            pick_found = ({1'b0, i_sel} < (SW+1)'(NCH));
        end else begin
            pick_idx   = rr_idx;
            pick_found = rr_found;
        end
    end

    assign accept      = |(i_valid & o_ready);
    assign rr_ptr_next = (pick_idx == SW'(NCH - 1)) ? '0 : pick_idx + 1'b1;

    // Output beat register: load on acceptance, otherwise drop valid once drained.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
            grant_reg <= '0;
        end else if (accept) begin
            data_reg  <= ch_data[pick_idx];
            grant_reg <= pick_idx;
            valid_reg <= 1'b1;
        end else if (i_ready) begin
            valid_reg <= 1'b0;
        end
    end

    // Round-robin pointer moves past the channel just served.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rr_ptr_reg <= '0;
        end else if (MODE == 1 && accept) begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    assign o_data  = data_reg;
    assign o_valid = valid_reg;
    assign o_grant = grant_reg;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Directed bench for mux_arb_nto1: select mode (NCH=4), round-robin mode (NCH=4)
// and select mode with an out-of-range select (NCH=3).
module tb_mux_arb_nto1;

    localparam logic [31:0] D0 = 32'h000000A0;
    localparam logic [31:0] D1 = 32'h000000B1;
    localparam logic [31:0] D2 = 32'hDEADBEEF;
    localparam logic [31:0] D3 = 32'h000000D3;

    typedef struct {
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic        ready;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [31:0] exp_data;
        logic [1:0]  exp_grant;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // u0: MODE=0, NCH=4
    logic [127:0] data0;
    logic [3:0]   valid0, ordy0;
    logic [1:0]   sel0, og0;
    logic         ready0, ov0;
    logic [31:0]  od0;

    // u1: MODE=1, NCH=4
    logic [127:0] data1;
    logic [3:0]   valid1, ordy1;
    logic [1:0]   sel1, og1;
    logic         ready1, ov1;
    logic [31:0]  od1;

    // u2: MODE=0, NCH=3
    logic [95:0]  data2;
    logic [2:0]   valid2, ordy2;
    logic [1:0]   sel2, og2;
    logic         ready2, ov2;
    logic [31:0]  od2;

    int checks   = 0;
    int failures = 0;

    vec_t t0 [8];
    vec_t t1 [14];

    always #5 clk = ~clk;

    mux_arb_nto1 #(.WIDTH(32), .NCH(4), .MODE(0)) u0 (
        .i_clk(clk), .i_reset(rst_n), .i_data(data0), .i_valid(valid0), .o_ready(ordy0),
        .i_sel(sel0), .o_data(od0), .o_valid(ov0), .i_ready(ready0), .o_grant(og0)
    );

    mux_arb_nto1 #(.WIDTH(32), .NCH(4), .MODE(1)) u1 (
        .i_clk(clk), .i_reset(rst_n), .i_data(data1), .i_valid(valid1), .o_ready(ordy1),
        .i_sel(sel1), .o_data(od1), .o_valid(ov1), .i_ready(ready1), .o_grant(og1)
    );

    mux_arb_nto1 #(.WIDTH(32), .NCH(3), .MODE(0)) u2 (
        .i_clk(clk), .i_reset(rst_n), .i_data(data2), .i_valid(valid2), .o_ready(ordy2),
        .i_sel(sel2), .o_data(od2), .o_valid(ov2), .i_ready(ready2), .o_grant(og2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] sel, input logic [3:0] valid, input logic ready,
                                input logic [3:0] exp_rdy, input logic exp_ov,
                                input logic [31:0] exp_data, input logic [1:0] exp_grant);
        vec_t v;
        v.sel = sel; v.valid = valid; v.ready = ready;
        v.exp_rdy = exp_rdy; v.exp_ov = exp_ov; v.exp_data = exp_data; v.exp_grant = exp_grant;
        return v;
    endfunction

    function automatic logic [31:0] dch(input int k);
        case (k)
            0:       return D0;
            1:       return D1;
            2:       return D2;
            default: return D3;
        endcase
    endfunction

    initial begin
        // Select mode: expected ready before the edge, then registered outputs after it.
        t0[0] = mk(2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, D2, 2'd2);
        t0[1] = mk(2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1, D2, 2'd2);
        t0[2] = mk(2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1, D1, 2'd1);
        t0[3] = mk(2'd3, 4'b0000, 1'b1, 4'b1000, 1'b0, D1, 2'd1);
        t0[4] = mk(2'd0, 4'b0001, 1'b0, 4'b0001, 1'b1, D0, 2'd0);
        t0[5] = mk(2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1, D3, 2'd3);
        t0[6] = mk(2'd0, 4'b0000, 1'b0, 4'b0000, 1'b1, D3, 2'd3);
        t0[7] = mk(2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, D0, 2'd0);

        // Round-robin: full rotation, then the sparse 4'b1010 pattern from rr_ptr=2.
        for (int i = 0; i < 8; i++) begin
            t1[i] = mk(2'd0, 4'b1111, 1'b1, 4'(1 << (i % 4)), 1'b1, dch(i % 4), 2'(i % 4));
        end
        t1[8]  = mk(2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, D1, 2'd1);
        t1[9]  = mk(2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, D3, 2'd3);
        t1[10] = mk(2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, D1, 2'd1);
        t1[11] = mk(2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, D3, 2'd3);
        t1[12] = mk(2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, D3, 2'd3);
        t1[13] = mk(2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, D3, 2'd3);

        data0 = {D3, D2, D1, D0};
        data1 = {D3, D2, D1, D0};
        data2 = {32'h22222222, 32'h11111111, 32'h00000000};
        sel0 = '0; sel1 = '0; sel2 = '0;
        ready0 = 1'b1; ready1 = 1'b1; ready2 = 1'b1;
        valid0 = 4'b1111; valid1 = 4'b1111; valid2 = 3'b111;

        // Reset state, with every channel offering data.
        repeat (2) @(posedge clk);
        #1;
        chk("reset u0 o_ready", 32'(ordy0), 32'h0);
        chk("reset u1 o_ready", 32'(ordy1), 32'h0);
        chk("reset u2 o_ready", 32'(ordy2), 32'h0);
        chk("reset u1 o_valid", 32'(ov1), 32'h0);
        chk("reset u0 o_data", od0, 32'h0);
        chk("reset u1 o_grant", 32'(og1), 32'h0);
        $display("reset: o_ready u0=%b u1=%b u2=%b o_valid u1=%b", ordy0, ordy1, ordy2, ov1);
        valid0 = '0; valid1 = '0; valid2 = '0;
        ready1 = 1'b0; ready2 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Select-mode table.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sel0 = t0[i].sel; valid0 = t0[i].valid; ready0 = t0[i].ready;
            #1;
            chk($sformatf("u0[%0d] o_ready", i), 32'(ordy0), 32'(t0[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("u0[%0d] o_valid", i), 32'(ov0), 32'(t0[i].exp_ov));
            chk($sformatf("u0[%0d] o_data", i), od0, t0[i].exp_data);
            chk($sformatf("u0[%0d] o_grant", i), 32'(og0), 32'(t0[i].exp_grant));
            $display("u0 vec %0d sel=%0d valid=%b ready=%b -> o_valid=%b o_data=%h o_grant=%0d",
                     i, t0[i].sel, t0[i].valid, t0[i].ready, ov0, od0, og0);
        end
        @(negedge clk);
        valid0 = '0; ready0 = 1'b0;

        // Round-robin table.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            valid1 = t1[i].valid; ready1 = t1[i].ready;
            #1;
            chk($sformatf("u1[%0d] o_ready", i), 32'(ordy1), 32'(t1[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("u1[%0d] o_valid", i), 32'(ov1), 32'(t1[i].exp_ov));
            chk($sformatf("u1[%0d] o_data", i), od1, t1[i].exp_data);
            chk($sformatf("u1[%0d] o_grant", i), 32'(og1), 32'(t1[i].exp_grant));
            $display("u1 vec %0d valid=%b ready=%b -> o_valid=%b o_data=%h o_grant=%0d",
                     i, t1[i].valid, t1[i].ready, ov1, od1, og1);
        end

        // Out-of-range select on a 3-channel mux, then a legal select.
        @(negedge clk);
        sel2 = 2'd3; valid2 = 3'b111; ready2 = 1'b1;
        #1;
        chk("u2 sel=3 o_ready", 32'(ordy2), 32'h0);
        @(posedge clk);
        #1;
        chk("u2 sel=3 o_valid", 32'(ov2), 32'h0);
        $display("u2 sel=3 valid=111 -> o_ready=%b o_valid=%b", ordy2, ov2);
        @(negedge clk);
        sel2 = 2'd2;
        #1;
        chk("u2 sel=2 o_ready", 32'(ordy2), 32'h4);
        @(posedge clk);
        #1;
        chk("u2 sel=2 o_valid", 32'(ov2), 32'h1);
        chk("u2 sel=2 o_data", od2, 32'h22222222);
        chk("u2 sel=2 o_grant", 32'(og2), 32'h2);
        $display("u2 sel=2 valid=111 -> o_ready=%b o_valid=%b o_data=%h o_grant=%0d", ordy2, ov2, od2, og2);
        @(negedge clk);
        valid2 = '0; ready2 = 1'b0;

        // Backpressure: hold a 0x11 beat for three stalled cycles, then drain with no bubble.
        @(negedge clk);
        data1[31:0] = 32'h00000011; valid1 = 4'b0001; ready1 = 1'b1;
        #1;
        chk("bp load o_ready", 32'(ordy1), 32'h1);
        @(posedge clk);
        #1;
        chk("bp load o_data", od1, 32'h11);
        $display("bp load -> o_valid=%b o_data=%h o_grant=%0d", ov1, od1, og1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            valid1 = 4'b1111; ready1 = 1'b0;
            #1;
            chk($sformatf("bp stall%0d o_ready", i), 32'(ordy1), 32'h0);
            @(posedge clk);
            #1;
            chk($sformatf("bp stall%0d o_data", i), od1, 32'h11);
            chk($sformatf("bp stall%0d o_valid", i), 32'(ov1), 32'h1);
            chk($sformatf("bp stall%0d o_grant", i), 32'(og1), 32'h0);
            $display("bp stall %0d -> o_ready=%b o_valid=%b o_data=%h", i, ordy1, ov1, od1);
        end
        @(negedge clk);
        ready1 = 1'b1;
        #1;
        chk("bp release o_ready", 32'(ordy1), 32'h2);
        @(posedge clk);
        #1;
        chk("bp release o_data", od1, D1);
        chk("bp release o_grant", 32'(og1), 32'h1);
        chk("bp release o_valid", 32'(ov1), 32'h1);
        $display("bp release -> o_valid=%b o_data=%h o_grant=%0d", ov1, od1, og1);

        // Move rr_ptr to 3 with a held beat, then reset between edges.
        @(negedge clk);
        valid1 = 4'b0100;
        #1;
        chk("pre-reset o_ready", 32'(ordy1), 32'h4);
        @(posedge clk);
        #1;
        chk("pre-reset o_grant", 32'(og1), 32'h2);
        chk("pre-reset o_valid", 32'(ov1), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-reset o_valid", 32'(ov1), 32'h0);
        chk("mid-reset o_data", od1, 32'h0);
        chk("mid-reset o_grant", 32'(og1), 32'h0);
        chk("mid-reset o_ready", 32'(ordy1), 32'h0);
        $display("mid-reset -> o_valid=%b o_data=%h o_grant=%0d o_ready=%b", ov1, od1, og1, ordy1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        valid1 = 4'b1111; ready1 = 1'b1;
        #1;
        chk("post-reset o_ready", 32'(ordy1), 32'h1);
        @(posedge clk);
        #1;
        chk("post-reset o_grant", 32'(og1), 32'h0);
        chk("post-reset o_valid", 32'(ov1), 32'h1);
        chk("post-reset o_data", od1, 32'h11);
        $display("post-reset -> o_valid=%b o_data=%h o_grant=%0d", ov1, od1, og1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
